// File: rtl/steg_pkg.sv
// Shared definitions for the LSB steganography embedder: FSM encoding and
// the parameter legality check used at elaboration.
package steg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EMBED    = 2'd1,
        ST_WAIT_MSG = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    function automatic bit params_legal(input int bps, input int nlsb,
                                        input int channels, input int msg_w);
        return (nlsb >= 1) && (nlsb <= 8) && (nlsb < bps) && (channels >= 1) &&
               (msg_w >= nlsb) && ((msg_w % nlsb) == 0);
    endfunction

endpackage

// File: rtl/lsb_insert.sv
// Replaces the NLSB low bits of one audio sample with message bits;
// bits[NLSB-1] is the earliest-consumed message bit.
module lsb_insert #(
    parameter int BPS  = 24,
    parameter int NLSB = 2
) (
    input  logic [BPS-1:0]  sample,
    input  logic [NLSB-1:0] bits,
    output logic [BPS-1:0]  result
);

    localparam logic [BPS-1:0] KEEP_MASK = {{(BPS-NLSB){1'b1}}, {NLSB{1'b0}}};

    always_comb begin
        result = (sample & KEEP_MASK) | BPS'(bits);
    end

endmodule

// File: rtl/bit_embedder_par.sv
// Frame-level LSB embedder: one channel per cycle, stalls in WAIT_MSG when the
// message buffer runs dry, publishes the finished frame with a one-cycle pulse.
//
// state    | meaning
// IDLE     | waiting for in_enable; frame accepted here only
// EMBED    | one channel processed per cycle, channel 0 first
// WAIT_MSG | message buffer empty mid-frame, waiting for a word
// DONE     | copy working frame to out_frame, pulse out_ready
module bit_embedder_par
    import steg_pkg::*;
#(
    parameter int BPS      = 24,
    parameter int NLSB     = 2,
    parameter int CHANNELS = 2,
    parameter int MSG_W    = 8
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_enable,
    input  logic [CHANNELS*BPS-1:0] in_frame,
    input  logic                    in_bypass,
    input  logic [MSG_W-1:0]        in_msg_data,
    input  logic                    in_msg_valid,
    output logic                    out_msg_ready,
    output logic [CHANNELS*BPS-1:0] out_frame,
    output logic                    out_ready,
    output logic                    out_busy
);

    if (!params_legal(BPS, NLSB, CHANNELS, MSG_W)) begin : g_bad_params
        $error("bit_embedder_par: illegal BPS/NLSB/CHANNELS/MSG_W combination");
    end

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(MSG_W + 1);

    state_t                    state, state_nxt;
    logic [CHANNELS*BPS-1:0]   work_frame;
    logic                      bypass_q;
    logic [CH_W-1:0]           ch_cnt;
    logic [MSG_W-1:0]          msg_buf, msg_buf_nxt;
    logic [CNT_W-1:0]          bit_cnt, bit_cnt_nxt;
    logic                      msg_ready_q;
    logic                      load, advance, consume, last_ch, buf_empty;
    logic [BPS-1:0]            cur_sample, new_sample;

    assign load       = in_msg_valid & msg_ready_q;
    assign buf_empty  = (bit_cnt == '0);
    assign last_ch    = (ch_cnt == CH_W'(CHANNELS - 1));
    assign cur_sample = work_frame[int'(ch_cnt)*BPS +: BPS];

    lsb_insert #(.BPS(BPS), .NLSB(NLSB)) u_lsb_insert (
        .sample (cur_sample),
        .bits   (msg_buf[MSG_W-1 -: NLSB]),
        .result (new_sample)
    );

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        consume   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_enable) state_nxt = ST_EMBED;
            end
            ST_EMBED: begin
                if (bypass_q || !buf_empty) begin
                    advance = 1'b1;
                    consume = !bypass_q;
                    if (last_ch) state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_WAIT_MSG;
                end
            end
            // !buf_empty covers a word that landed on the same edge we stalled
            ST_WAIT_MSG: begin
                if (load || !buf_empty) state_nxt = ST_EMBED;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        msg_buf_nxt = msg_buf;
        bit_cnt_nxt = bit_cnt;
        if (load) begin
            msg_buf_nxt = in_msg_data;
            bit_cnt_nxt = CNT_W'(MSG_W);
        end else if (consume) begin
            msg_buf_nxt = msg_buf << NLSB;
            bit_cnt_nxt = bit_cnt - CNT_W'(NLSB);
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state       <= ST_IDLE;
            work_frame  <= '0;
            bypass_q    <= 1'b0;
            ch_cnt      <= '0;
            msg_buf     <= '0;
            bit_cnt     <= '0;
            msg_ready_q <= 1'b1;
            out_frame   <= '0;
            out_ready   <= 1'b0;
        end else begin
            state       <= state_nxt;
            msg_buf     <= msg_buf_nxt;
            bit_cnt     <= bit_cnt_nxt;
            msg_ready_q <= (bit_cnt_nxt == '0);
            out_ready   <= 1'b0;
            if (state == ST_IDLE && in_enable) begin
                work_frame <= in_frame;
                bypass_q   <= in_bypass;
                ch_cnt     <= '0;
            end
            if (advance) begin
                ch_cnt <= ch_cnt + CH_W'(1);
                if (consume) work_frame[int'(ch_cnt)*BPS +: BPS] <= new_sample;
            end
            if (state == ST_DONE) begin
                out_frame <= work_frame;
                out_ready <= 1'b1;
            end
        end
    end

    assign out_busy      = (state != ST_IDLE);
    assign out_msg_ready = msg_ready_q;

endmodule
